// File: rtl/ultrasound_arbiter.sv
// Round-robin arbiter for the shared ultrasound ranging resource.
// Requester 0 is the navigation FSM and requester 1 is the display/telemetry sweep.
// Each grant issues one sensor_run pulse. The arbiter then waits for sensor_done,
// or gives up after TIMEOUT_CYCLES. After sensor_done it waits SETTLE_CYCLES,
// then latches sensor_location into the owner's result register and pulses done.
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous, active-high
//   req[1:0]        per-requester start pulses (captured into pending bits)
//   sensor_done     completion pulse from the ultrasound module
//   sensor_location rover location {theta[11:8], r[7:0]}
//   sensor_run      one-cycle start pulse to the ultrasound module
//   busy            high whenever the arbiter is not idle
//   owner           current or most recent grantee (round-robin pointer)
//   done[1:0]       one-cycle completion pulse per requester
//   timeout_err[1:0] one-cycle pulse alongside done[i] when request i timed out
//   location_0/1    last successful result per requester
module ultrasound_arbiter #(
    parameter int unsigned SETTLE_CYCLES  = 27000000,
    parameter int unsigned TIMEOUT_CYCLES = 54000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic        sensor_done,
    input  logic [11:0] sensor_location,
    output logic        sensor_run,
    output logic        busy,
    output logic        owner,
    output logic [1:0]  done,
    output logic [1:0]  timeout_err,
    output logic [11:0] location_0,
    output logic [11:0] location_1
);

    localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] SettleLast  = 32'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StWaitDone,
        StSettle
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [1:0]  pending_q, pending_d;
    logic        owner_q, owner_d;
    logic        run_q, run_d;
    logic        busy_q, busy_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  terr_q, terr_d;
    logic [11:0] loc0_q, loc0_d;
    logic [11:0] loc1_q, loc1_d;
    logic        grant_idx;

    // With both requests pending, the one that did not go last wins.
    assign grant_idx = (pending_q == 2'b11) ? ~owner_q : pending_q[1];

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        pending_d = pending_q | req;
        owner_d   = owner_q;
        run_d     = 1'b0;
        done_d    = 2'b00;
        terr_d    = 2'b00;
        loc0_d    = loc0_q;
        loc1_d    = loc1_q;

        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    owner_d   = grant_idx;
                    run_d     = 1'b1;
                    counter_d = '0;
                    state_d   = StWaitDone;
                    // A req on the grant edge re-queues one more request.
                    pending_d[grant_idx] = req[grant_idx];
                end
            end
            StWaitDone: begin
                counter_d = counter_q + 32'd1;
                // sensor_done takes priority over a coincident timeout.
                if (sensor_done) begin
                    counter_d = '0;
                    state_d   = StSettle;
                end else if (counter_q == TimeoutLast) begin
                    done_d[owner_q] = 1'b1;
                    terr_d[owner_q] = 1'b1;
                    state_d         = StIdle;
                end
            end
            StSettle: begin
                counter_d = counter_q + 32'd1;
                if (counter_q == SettleLast) begin
                    if (owner_q) begin
                        loc1_d = sensor_location;
                    end else begin
                        loc0_d = sensor_location;
                    end
                    done_d[owner_q] = 1'b1;
                    state_d         = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            counter_q <= '0;
            pending_q <= 2'b00;
            owner_q   <= 1'b1;
            run_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 2'b00;
            terr_q    <= 2'b00;
            loc0_q    <= '0;
            loc1_q    <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            pending_q <= pending_d;
            owner_q   <= owner_d;
            run_q     <= run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            terr_q    <= terr_d;
            loc0_q    <= loc0_d;
            loc1_q    <= loc1_d;
        end
    end

    assign sensor_run  = run_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign location_0  = loc0_q;
    assign location_1  = loc1_q;

endmodule

// File: tb/tb_ultrasound_arbiter.sv
// Self-checking bench for ultrasound_arbiter with SETTLE_CYCLES=3, TIMEOUT_CYCLES=20.
module tb_ultrasound_arbiter;

    localparam int unsigned Settle  = 3;
    localparam int unsigned Timeout = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic        sensor_done = 1'b0;
    logic [11:0] sensor_location = 12'h000;
    logic        sensor_run;
    logic        busy;
    logic        owner;
    logic [1:0]  done;
    logic [1:0]  timeout_err;
    logic [11:0] location_0;
    logic [11:0] location_1;

    int n_checks = 0;
    int n_fail   = 0;

    ultrasound_arbiter #(
        .SETTLE_CYCLES (Settle),
        .TIMEOUT_CYCLES(Timeout)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .sensor_done    (sensor_done),
        .sensor_location(sensor_location),
        .sensor_run     (sensor_run),
        .busy           (busy),
        .owner          (owner),
        .done           (done),
        .timeout_err    (timeout_err),
        .location_0     (location_0),
        .location_1     (location_1)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        sd;
        logic [11:0] loc;
        logic        run;
        logic        busy;
        logic        own;
        logic [1:0]  done;
        logic [1:0]  terr;
        logic [11:0] l0;
        logic [11:0] l1;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rst, input logic [1:0] rq, input logic sd,
                     input logic [11:0] loc, input logic run, input logic bsy,
                     input logic own, input logic [1:0] dn, input logic [1:0] te,
                     input logic [11:0] l0, input logic [11:0] l1);
        vec_t e;
        e.rst = rst; e.req = rq; e.sd = sd; e.loc = loc;
        e.run = run; e.busy = bsy; e.own = own; e.done = dn; e.terr = te;
        e.l0 = l0; e.l1 = l1;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive inputs, clock one rising edge, then sample 1 time unit later.
    task automatic step(input logic rst, input logic [1:0] rq, input logic sd,
                        input logic [11:0] loc);
        reset = rst;
        req = rq;
        sensor_done = sd;
        sensor_location = loc;
        @(posedge clock);
        #1;
    endtask

    logic [11:0] cur_loc;
    logic        exp_grant;
    logic        exp_done_idx;
    int          grants;
    int          dones;
    logic        sd_next;

    initial begin
        // Test 1: single request from requester 0, sensor_done 4 cycles after run.
        v(1, 2'b00, 0, 12'h000, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b01, 0, 12'h3A5, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 1, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 1, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 0, 0, 2'b01, 2'b00, 12'h3A5, 12'h000);
        // sensor_done while idle must be ignored
        v(0, 2'b00, 1, 12'h3A5, 0, 0, 0, 2'b00, 2'b00, 12'h3A5, 12'h000);
        v(0, 2'b00, 0, 12'h3A5, 0, 0, 0, 2'b00, 2'b00, 12'h3A5, 12'h000);
        // Test 2: simultaneous requests after reset; requester 0 first.
        v(1, 2'b00, 0, 12'h000, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b11, 0, 12'h111, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h111, 1, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h111, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 1, 12'h111, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h111, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h111, 0, 1, 0, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h111, 0, 0, 0, 2'b01, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 0, 12'h222, 1, 1, 1, 2'b00, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 0, 12'h222, 0, 1, 1, 2'b00, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 1, 12'h222, 0, 1, 1, 2'b00, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 0, 12'h222, 0, 1, 1, 2'b00, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 0, 12'h222, 0, 1, 1, 2'b00, 2'b00, 12'h111, 12'h000);
        v(0, 2'b00, 0, 12'h222, 0, 0, 1, 2'b10, 2'b00, 12'h111, 12'h222);
        v(0, 2'b00, 0, 12'h222, 0, 0, 1, 2'b00, 2'b00, 12'h111, 12'h222);
        // Test 6: reset mid-SETTLE with requester 1 queued; pending must clear.
        v(0, 2'b01, 0, 12'h555, 0, 0, 1, 2'b00, 2'b00, 12'h111, 12'h222);
        v(0, 2'b00, 0, 12'h555, 1, 1, 0, 2'b00, 2'b00, 12'h111, 12'h222);
        v(0, 2'b10, 0, 12'h555, 0, 1, 0, 2'b00, 2'b00, 12'h111, 12'h222);
        v(0, 2'b00, 1, 12'h555, 0, 1, 0, 2'b00, 2'b00, 12'h111, 12'h222);
        v(0, 2'b00, 0, 12'h555, 0, 1, 0, 2'b00, 2'b00, 12'h111, 12'h222);
        v(1, 2'b00, 0, 12'h555, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h555, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);
        v(0, 2'b00, 0, 12'h555, 0, 0, 1, 2'b00, 2'b00, 12'h000, 12'h000);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].sd, vecs[i].loc);
            check($sformatf("v%0d sensor_run", i), 32'(sensor_run), 32'(vecs[i].run));
            check($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            check($sformatf("v%0d owner", i), 32'(owner), 32'(vecs[i].own));
            check($sformatf("v%0d done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("v%0d timeout_err", i), 32'(timeout_err), 32'(vecs[i].terr));
            check($sformatf("v%0d location_0", i), 32'(location_0), 32'(vecs[i].l0));
            check($sformatf("v%0d location_1", i), 32'(location_1), 32'(vecs[i].l1));
        end

        // Test 5: sensor_done on the edge where counter = TIMEOUT-1 wins.
        cur_loc = 12'h7E1;
        step(0, 2'b01, 0, cur_loc);
        step(0, 2'b00, 0, cur_loc);              // grant edge g
        check("race grant run", 32'(sensor_run), 32'd1);
        check("race grant owner", 32'(owner), 32'd0);
        for (int i = 1; i < int'(Timeout); i++) begin
            step(0, 2'b00, 0, cur_loc);
        end
        step(0, 2'b00, 1, cur_loc);              // edge g+TIMEOUT
        check("race busy", 32'(busy), 32'd1);
        check("race no done", 32'(done), 32'd0);
        check("race no terr", 32'(timeout_err), 32'd0);
        for (int i = 1; i < int'(Settle); i++) begin
            step(0, 2'b00, 0, cur_loc);
            check("race settle no done", 32'(done), 32'd0);
        end
        step(0, 2'b00, 0, cur_loc);
        check("race done", 32'(done), 32'd1);
        check("race terr", 32'(timeout_err), 32'd0);
        check("race location_0", 32'(location_0), 32'h7E1);

        // Test 4: timeout; location_0 keeps its prior value.
        step(0, 2'b01, 0, 12'hABC);
        step(0, 2'b00, 0, 12'hABC);              // grant edge g
        check("tmo grant run", 32'(sensor_run), 32'd1);
        for (int i = 1; i < int'(Timeout); i++) begin
            step(0, 2'b00, 0, 12'hABC);
            if (i == 1 || i == int'(Timeout) - 1) begin
                check("tmo early done", 32'(done), 32'd0);
                check("tmo busy", 32'(busy), 32'd1);
            end
        end
        step(0, 2'b00, 0, 12'hABC);              // edge g+TIMEOUT
        check("tmo done", 32'(done), 32'd1);
        check("tmo terr", 32'(timeout_err), 32'd1);
        check("tmo location_0 kept", 32'(location_0), 32'h7E1);
        check("tmo idle", 32'(busy), 32'd0);
        step(0, 2'b00, 0, 12'hABC);
        check("tmo done cleared", 32'(done), 32'd0);
        check("tmo terr cleared", 32'(timeout_err), 32'd0);
        check("tmo stays idle", 32'(sensor_run), 32'd0);

        // Test 3: both requesters keep pulsing; grants and dones must alternate.
        // owner is 0 after the timeout, so requester 1 goes first.
        exp_grant = 1'b1;
        exp_done_idx = 1'b1;
        grants = 0;
        dones = 0;
        sd_next = 1'b0;
        for (int cyc = 0; cyc < 200 && dones < 4; cyc++) begin
            step(0, 2'b11, sd_next, 12'h0F0 + 12'(cyc));
            sd_next = sensor_run;
            if (sensor_run) begin
                check($sformatf("rr grant %0d", grants), 32'(owner), 32'(exp_grant));
                exp_grant = ~exp_grant;
                grants++;
            end
            if (done != 2'b00) begin
                check($sformatf("rr done %0d", dones), 32'(done), 32'(2'b01 << exp_done_idx));
                exp_done_idx = ~exp_done_idx;
                dones++;
            end
        end
        check("rr done count", 32'(dones), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
